// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM states and the fixed results
// returned for divide-by-zero and signed divide overflow.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply or
// restoring divide, one step per cycle, with done after ITER steps.
module muldiv_iter_core #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic              step,
    input  logic              isDiv,
    input  logic [XLEN-1:0]   opA,
    input  logic [XLEN-1:0]   opB,
    output logic              done,
    output logic [2*XLEN-1:0] res
);
    localparam int CW = $clog2(ITER + 1);

    logic [CW-1:0]   cnt;
    logic            mode;
    logic [XLEN-1:0] operand;
    logic [2*XLEN:0] acc;
    logic [2*XLEN:0] accNext;
    logic [XLEN:0]   hiSum;
    logic [XLEN+1:0] diff;

    // Multiply: acc = {partial product, unconsumed multiplier bits}.
    // Divide:   acc = {partial remainder, dividend/quotient bits}.
    always_comb begin
        hiSum   = acc[2*XLEN:XLEN] + {1'b0, operand};
        diff    = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, operand};
        accNext = acc;
        if (mode) begin
            if (!diff[XLEN+1])
                accNext = {diff[XLEN:0], acc[XLEN-2:0], 1'b1};
            else
                accNext = {acc[2*XLEN-1:0], 1'b0};
        end else begin
            if (acc[0])
                accNext = {1'b0, hiSum, acc[XLEN-1:1]};
            else
                accNext = {1'b0, acc[2*XLEN:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt     <= '0;
            mode    <= 1'b0;
            operand <= '0;
            acc     <= '0;
        end else if (load) begin
            cnt     <= '0;
            mode    <= isDiv;
            operand <= isDiv ? opB : opA;
            acc     <= {{(XLEN+1){1'b0}}, (isDiv ? opA : opB)};
        end else if (step && !done) begin
            cnt <= cnt + 1'b1;
            acc <= accNext;
        end
    end

    assign done = (cnt == CW'(ITER));
    assign res  = acc[2*XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: sign handling, special-case fast path
// and IDLE/CALC/DONE control around the iterative core.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ITER       = XLEN
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       rs1Data,
    input  logic [XLEN-1:0]       rs2Data,
    input  logic [REG_ADDR_W-1:0] rdIn,
    input  logic                  flush,
    output logic                  busy,
    output logic                  resultValid,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rdOut
);
    import rv32m_pkg::*;

    state_t                state, stateNext;
    logic [2:0]            f3;
    logic [REG_ADDR_W-1:0] rdLat;
    logic                  negA, negB, special;
    logic [XLEN-1:0]       specRes;

    logic                  aSigned, bSigned, negAIn, negBIn, div0In, ovfIn;
    logic [XLEN-1:0]       magA, magB, specResIn;
    logic                  accept, finish, coreDone;
    logic [2*XLEN-1:0]     coreRes;

    function automatic logic [XLEN-1:0] mulSel(input logic [2*XLEN-1:0] p,
                                               input logic neg, input logic hi);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] divSel(input logic [2*XLEN-1:0] qr,
                                               input logic negQ, input logic negR,
                                               input logic rem);
        logic [XLEN-1:0] q, r;
        q = qr[XLEN-1:0];
        r = qr[2*XLEN-1:XLEN];
        if (rem)
            return negR ? -r : r;
        return negQ ? -q : q;
    endfunction

    always_comb begin
        aSigned = 1'b0;
        bSigned = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                aSigned = 1'b1;
                bSigned = 1'b1;
            end
            F3_MULHSU: aSigned = 1'b1;
            default: ;
        endcase
        negAIn = aSigned & rs1Data[XLEN-1];
        negBIn = bSigned & rs2Data[XLEN-1];
        magA   = negAIn ? -rs1Data : rs1Data;
        magB   = negBIn ? -rs2Data : rs2Data;
        div0In = funct3[2] && (rs2Data == '0);
        ovfIn  = funct3[2] && !funct3[0] && (rs1Data == OVF_Q) && (rs2Data == '1);
        // Remainder variants (funct3[1]) return the dividend / zero.
        specResIn = '0;
        if (div0In)
            specResIn = funct3[1] ? rs1Data : DIV0_Q;
        else if (ovfIn)
            specResIn = funct3[1] ? '0 : OVF_Q;
    end

    assign accept = (state == IDLE) && start && !flush;
    // Special cases spend a single CALC cycle so both paths share the finish edge.
    assign finish = (state == CALC) && !flush && (special || coreDone);

    muldiv_iter_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (accept),
        .step  ((state == CALC) && !special),
        .isDiv (funct3[2]),
        .opA   (magA),
        .opB   (magB),
        .done  (coreDone),
        .res   (coreRes)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = CALC;
            CALC:    if (finish) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush)
            stateNext = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            f3      <= '0;
            rdLat   <= '0;
            negA    <= 1'b0;
            negB    <= 1'b0;
            special <= 1'b0;
            specRes <= '0;
            result  <= '0;
            rdOut   <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                f3      <= funct3;
                rdLat   <= rdIn;
                negA    <= negAIn;
                negB    <= negBIn;
                special <= div0In || ovfIn;
                specRes <= specResIn;
            end
            if (finish) begin
                rdOut <= rdLat;
                if (special)
                    result <= specRes;
                else if (f3[2])
                    result <= divSel(coreRes, negA ^ negB, negA, f3[1]);
                else
                    result <= mulSel(coreRes, negA ^ negB, f3 != F3_MUL);
            end
        end
    end

    assign busy        = (state != IDLE);
    assign resultValid = (state == DONE) && !flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model plus a per-cycle scoreboard
// on resultValid/result/rdOut timing, with literal results pinning the model.
module tb_muldiv_unit;
    logic        Clk = 1'b0;
    logic        Rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1Data, rs2Data, result;
    logic [4:0]  rdIn, rdOut;
    logic        busy, resultValid;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit dut (
        .Clk(Clk), .Rst(Rst), .start(start), .funct3(funct3),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .rdIn(rdIn), .flush(flush),
        .busy(busy), .resultValid(resultValid), .result(result), .rdOut(rdOut)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int ia, ib;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = a;
        ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: a pulse must appear exactly on each expected cycle and nowhere else.
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("valid_pulse", {31'd0, resultValid}, 32'd1);
                chk("result", result, exp_q[0].res);
                chk("rdOut", {27'd0, rdOut}, {27'd0, exp_q[0].rd});
                void'(exp_q.pop_front());
            end else begin
                chk("no_pulse", {31'd0, resultValid}, 32'd0);
            end
        end
    end

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        exp_t e;
        bit fast;
        @(negedge Clk);
        funct3 = f3; rs1Data = a; rs2Data = b; rdIn = rd; start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.res = model(f3, a, b);
        e.rd  = rd;
        e.due = cyc + (fast ? 1 : 33);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (busy && n < 60);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit);
        chk("model_pin", model(f3, a, b), lit);
        launch(f3, a, b, rd);
        wait_idle();
        chk("result_lit", result, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1Data = '0; rs2Data = '0; rdIn = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, resultValid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rdOut", {27'd0, rdOut}, 32'd0);
        Rst = 1'b0;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
        run(3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
        run(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
        run(3'd6, 32'd5, 32'd0, 5'd14, 32'd5);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0);
        run(3'd0, 32'h0001_0001, 32'h0001_0001, 5'd31, 32'h0002_0001);

        // Flush mid-divide, then a fresh multiply at normal latency.
        launch(3'd4, 32'd1000, 32'd7, 5'd3);
        repeat (10) @(negedge Clk);
        flush = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        run(3'd0, 32'd3, 32'd4, 5'd4, 32'd12);

        // Flush during the DONE cycle hides the pulse.
        launch(3'd5, 32'd5, 32'd0, 5'd3);
        @(negedge Clk);
        @(negedge Clk);
        flush = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        flush = 1'b0;
        chk("flush_done_busy", {31'd0, busy}, 32'd0);

        // Start together with flush in IDLE is dropped.
        @(negedge Clk);
        funct3 = 3'd0; start = 1'b1; flush = 1'b1;
        @(negedge Clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", {31'd0, busy}, 32'd0);

        // Starts while busy (CALC and DONE) are ignored.
        launch(3'd0, 32'd5, 32'd6, 5'd7);
        for (int k = 0; k < 34; k++) begin
            @(negedge Clk);
            funct3 = 3'd5; rs1Data = 32'd99 + k; rs2Data = 32'd0; rdIn = 5'd20; start = 1'b1;
        end
        @(negedge Clk);
        start = 1'b0;
        wait_idle();
        chk("busy_start_result", result, 32'd30);
        repeat (3) @(negedge Clk);

        // Reset mid-CALC clears everything and no pulse follows.
        launch(3'd5, 32'd1000, 32'd3, 5'd11);
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, resultValid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_rdOut", {27'd0, rdOut}, 32'd0);
        Rst = 1'b0;
        repeat (40) @(negedge Clk);
        chk("post_rst_result", result, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
